// File: rtl/divider.sv
// Unsigned 32/32 radix-2 restoring divider with req/resp valid-ready handshakes.
// Result in 32 steps after acceptance; holds the result in DONE until resp_rdy.
module divider (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_msg_a,
    input  logic [31:0] req_msg_b,
    input  logic        req_val,
    output logic        req_rdy,
    output logic [63:0] resp_msg,
    output logic        resp_val,
    input  logic        resp_rdy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] b_q, b_d;
    logic        req_rdy_q, req_rdy_d;
    logic        resp_val_q, resp_val_d;
    logic [32:0] rem_shift;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        b_d       = b_q;
        // The partial remainder never exceeds 32 bits between steps, so only
        // the shifted trial value needs the extra bit for the compare.
        rem_shift = {rem_q, quo_q[31]};

        case (state_q)
            IDLE: begin
                if (req_val) begin
                    b_d     = req_msg_b;
                    quo_d   = req_msg_a;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (rem_shift >= {1'b0, b_q}) begin
                    rem_d = rem_shift[31:0] - b_q;
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_shift[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_rdy_d  = (state_d == IDLE);
        resp_val_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            b_q        <= '0;
            req_rdy_q  <= 1'b1;
            resp_val_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            b_q        <= b_d;
            req_rdy_q  <= req_rdy_d;
            resp_val_q <= resp_val_d;
        end
    end

    assign req_rdy  = req_rdy_q;
    assign resp_val = resp_val_q;
    assign resp_msg = {rem_q, quo_q};

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have ports: clk  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: req_msg_a  input  32  unsigned dividend.
REQ-004 SHALL have ports: req_msg_b  input  32  unsigned divisor.
REQ-005 SHALL have ports: req_val  input  1  operation request.
REQ-006 SHALL have ports: req_rdy  output  1  block can accept new operands.
REQ-007 SHALL have ports: resp_msg  output  64  result, {remainder[63:32], quotient[31:0]}.
REQ-008 SHALL have ports: resp_val  output  1  result valid.
REQ-009 SHALL have ports: resp_rdy  input  1  host accepts the result.
REQ-010 SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-011 SHALL have no parameters; all widths are fixed as listed.

Function
REQ-012 SHALL use a three-state FSM: IDLE, CALC, DONE.
REQ-013 SHALL drive req_rdy=1 only in IDLE and resp_val=1 only in DONE, both as registered state decodes.
REQ-014 SHALL complete a request handshake when req_val=1 and req_rdy=1 at a rising edge; on that edge it SHALL latch a and b, clear the partial remainder, load the quotient shift register with a, clear the step counter, and enter CALC.
REQ-015 SHALL ignore req_val and req_msg_* in CALC and DONE, so operand changes there have no effect.
REQ-016 SHALL use radix-2 restoring division in CALC, one step per edge. Each step: r' = {r[31:0], q[31]}; if r' >= {1'b0,b}, then r = r' - b and shift 1 into q; else r = r' and shift 0 into q. r is 33 bits wide.
REQ-017 SHALL perform exactly 32 steps. After the 32nd step edge, the FSM SHALL be in DONE, with resp_val=1 in the 32nd cycle after the acceptance edge.
REQ-018 SHALL hold resp_msg and resp_val stable while in DONE with resp_rdy=0, for any number of cycles.
REQ-019 SHALL treat resp_val=1 and resp_rdy=1 at an edge as response handshake complete; the FSM SHALL return to IDLE on that edge and req_rdy=1 SHALL follow in the next cycle.
REQ-020 SHALL ignore resp_rdy outside DONE.
REQ-021 SHALL produce a divide-by-zero result directly from the REQ-016 algorithm, with no special casing: b=0 gives quotient=32'hFFFFFFFF and remainder=a, with the same latency.
REQ-022 SHALL give results satisfying a = quotient*b + remainder with remainder < b for every b != 0, including a=0, a<b, a=b, and a=32'hFFFFFFFF.
REQ-023 SHALL keep resp_msg at its last computed value outside DONE; this value is don't-care to the host.
REQ-024 SHALL accept back-to-back operations with no bubble beyond the IDLE cycle: a DONE handshake is followed by one IDLE cycle, and a new request can then be accepted.

Reset
REQ-025 SHALL, while rst=1 at an edge, enter IDLE and clear the counter, r, q, and stored b, giving resp_msg=64'h0, resp_val=0, req_rdy=1 in the following cycle.
REQ-026 SHALL let rst override every other input, including assertion mid-CALC or in DONE; the in-flight result SHALL be discarded, no resp_val pulse SHALL occur, and a request can be accepted on the first edge after rst deasserts.
REQ-027 SHALL not complete a request handshake when req_val=1 in the same cycle as rst=1.

Verification
REQ-028 Bench SHALL cover: reset, then a=100, b=7, resp_rdy=1 -> resp_val=1 exactly 32 cycles after acceptance, resp_msg={32'd2, 32'd14}, req_rdy=1 one cycle after the response handshake.
REQ-029 Bench SHALL cover: a=32'hFFFFFFFF, b=1 -> quotient=32'hFFFFFFFF, remainder=0; then a=5, b=0 -> quotient=32'hFFFFFFFF, remainder=5.
REQ-030 Bench SHALL cover: a=3, b=10 with resp_rdy held 0 for 20 cycles after resp_val -> resp_msg={32'd3, 32'd0} stable throughout, req_rdy=0 throughout, and release on resp_rdy=1.
REQ-031 Bench SHALL cover: a=1000, b=10 accepted, then during CALC operands changed to a=9, b=3 with req_val=1 -> result still {0, 100}, and the second request is not accepted until IDLE.
REQ-032 Bench SHALL cover: rst pulsed at step 15 of CALC -> no resp_val pulse, outputs at reset values, and a fresh request a=50, b=5 then yields {0, 10}.
REQ-033 Bench SHALL cover: 10,000 random (a, b) pairs with random resp_rdy stalls -> every result matches a/b and a%b (b=0 per REQ-021), with exactly one response per accepted request.
